// File: rtl/mips_result_checker.sv
// mips_result_checker
//   Self-checking monitor for the MIPS pipeline core. Walks an ordered list of
//   checkpoints. Each checkpoint waits for a PC value, steers the core's
//   register-file display select, lets it settle, then compares the display
//   data with the expected value. A running-cycle watchdog bounds the run.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | after reset; cfg writes accepted, waiting for start
//   ARMED  | watching pc for slot[cur_idx].pc, watchdog counting
//   SETTLE | disp_sel held on slot[cur_idx].sel, compare on last cycle
//   DONE   | status held, cycle_count frozen; cfg writes and start accepted
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   cfg_we/idx/pc/sel/expect  checkpoint slot write (IDLE or DONE only)
//   start               one-cycle pulse, arms from IDLE or DONE
//   pc, disp_dat        core program counter and register display data
//   disp_sel            register display select to the core
//   busy/done/pass/fail/timeout/fail_idx/checks_passed/cycle_count  status
//   fail_data           captured mismatch data
//
// Optional build macro: CHECKER_CAPTURE_EN enables the fail_data capture
// register; without it fail_data is tied to 0.
module mips_result_checker #(
  parameter int DATA_W        = 32,
  parameter int PC_W          = 8,
  parameter int SEL_W         = 5,
  parameter int NUM_CHECKS    = 2,
  parameter int IDX_W         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 144,
  parameter int IDLE_SEL      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [PC_W-1:0]   cfg_pc,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [DATA_W-1:0] cfg_expect,
  input  logic              start,
  input  logic [31:0]       pc,
  input  logic [DATA_W-1:0] disp_dat,
  output logic [SEL_W-1:0]  disp_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [IDX_W-1:0]  checks_passed,
  output logic [31:0]       cycle_count,
  output logic [DATA_W-1:0] fail_data
);

  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SETTLE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]   slot_pc  [NUM_CHECKS];
  logic [SEL_W-1:0]  slot_sel [NUM_CHECKS];
  logic [DATA_W-1:0] slot_exp [NUM_CHECKS];

  logic [IDX_W-1:0]  cur_idx;
  logic [ST_W-1:0]   settle_cnt;
  logic [PC_W-1:0]   cur_pc;
  logic [SEL_W-1:0]  cur_sel;
  logic [DATA_W-1:0] cur_exp;

  logic cfg_open, do_start, running, wd_expire, pc_hit, settle_last, data_ok, last_slot;

  generate
    if (PC_W < 32) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^pc[31:PC_W];
    end
  endgenerate

  assign cfg_open = (state == S_IDLE) || (state == S_DONE);
  assign do_start = start && cfg_open;
  assign running  = (state == S_ARMED) || (state == S_SETTLE);
  assign busy     = running;

  // Slot write decode: an index outside 0..NUM_CHECKS-1 matches no slot.
  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_slot
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot_pc[i]  <= '0;
        slot_sel[i] <= '0;
        slot_exp[i] <= '0;
      end else if (cfg_we && cfg_open && (cfg_idx == IDX_W'(i))) begin
        slot_pc[i]  <= cfg_pc;
        slot_sel[i] <= cfg_sel;
        slot_exp[i] <= cfg_expect;
      end
    end
  end

  always_comb begin
    cur_pc  = '0;
    cur_sel = '0;
    cur_exp = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (cur_idx == IDX_W'(i)) begin
        cur_pc  = slot_pc[i];
        cur_sel = slot_sel[i];
        cur_exp = slot_exp[i];
      end
    end
  end

  // The watchdog outranks both the PC trigger and the compare.
  assign wd_expire   = running && (cycle_count >= 32'(TIMEOUT - 1));
  assign pc_hit      = (state == S_ARMED) && !wd_expire && (pc[PC_W-1:0] == cur_pc);
  assign settle_last = (state == S_SETTLE) && !wd_expire && (settle_cnt == '0);
  assign data_ok     = (disp_dat == cur_exp);
  assign last_slot   = (cur_idx == IDX_W'(NUM_CHECKS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ARMED;
      S_ARMED: begin
        if (wd_expire)   state_nxt = S_DONE;
        else if (pc_hit) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (wd_expire) state_nxt = S_DONE;
        else if (settle_last) state_nxt = (data_ok && !last_slot) ? S_ARMED : S_DONE;
      end
      S_DONE:   if (start) state_nxt = S_ARMED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_sel      <= SEL_W'(IDLE_SEL);
      cur_idx       <= '0;
      settle_cnt    <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      fail_idx      <= '0;
      checks_passed <= '0;
      cycle_count   <= '0;
    end else if (do_start) begin
      disp_sel      <= SEL_W'(IDLE_SEL);
      cur_idx       <= '0;
      settle_cnt    <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      fail_idx      <= '0;
      checks_passed <= '0;
      cycle_count   <= '0;
    end else begin
      if (running && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
      if (wd_expire) begin
        disp_sel <= SEL_W'(IDLE_SEL);
        done     <= 1'b1;
        fail     <= 1'b1;
        timeout  <= 1'b1;
        fail_idx <= cur_idx;
      end else if (pc_hit) begin
        disp_sel   <= cur_sel;
        settle_cnt <= ST_W'(SETTLE_CYCLES - 1);
      end else if (state == S_SETTLE) begin
        if (settle_last) begin
          disp_sel <= SEL_W'(IDLE_SEL);
          if (data_ok) begin
            checks_passed <= checks_passed + IDX_W'(1);
            cur_idx       <= cur_idx + IDX_W'(1);
            if (last_slot) begin
              done <= 1'b1;
              pass <= 1'b1;
            end
          end else begin
            done     <= 1'b1;
            fail     <= 1'b1;
            fail_idx <= cur_idx;
          end
        end else begin
          settle_cnt <= settle_cnt - ST_W'(1);
        end
      end
    end
  end

`ifdef CHECKER_CAPTURE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   fail_data <= '0;
    else if (do_start)                            fail_data <= '0;
    else if (wd_expire || (settle_last && !data_ok)) fail_data <= disp_dat;
  end
`else
  assign fail_data = '0;
`endif

endmodule
